// File: rtl/vend_output_seq.sv
// Vending machine output stage: validates the selection, dispenses the item for DISP_CYCLES
// cycles, then pays change (or a full refund) coin by coin over a valid/ready handshake.
// Optional macro STOCK_TRACK_EN adds per-item stock counters, a restock input and a sold_out
// output. Without it every item is always available.
module vend_output_seq #(
  parameter int unsigned W           = 8,
  parameter int unsigned N_ITEMS     = 4,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned DISP_CYCLES = 2,
  parameter int unsigned COIN_D0     = 20,
  parameter int unsigned COIN_D1     = 10,
  parameter int unsigned COIN_D2     = 5,
  parameter int unsigned COIN_D3     = 1
`ifdef STOCK_TRACK_EN
  ,
  parameter int unsigned STOCK_W     = 4,
  parameter int unsigned STOCK_INIT  = 15
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               end_trans,
  input  logic [SEL_W-1:0]   item_select,
  input  logic [W-1:0]       price,
  input  logic [W-1:0]       sum_money,
  output logic               busy,
  output logic [N_ITEMS-1:0] item_out,
  output logic [W-1:0]       change,
  output logic               coin_valid,
  output logic [1:0]         coin_sel,
  input  logic               coin_ready,
  output logic               done,
  output logic               ok
`ifdef STOCK_TRACK_EN
  ,
  input  logic               restock,
  output logic [N_ITEMS-1:0] sold_out
`endif
);

  typedef enum logic [2:0] {StIdle, StCheck, StDispense, StChange, StDone} state_e;

  localparam int unsigned DCW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
  localparam logic [DCW-1:0] DISP_LAST = DCW'(DISP_CYCLES - 1);

  localparam logic [W-1:0] D0 = W'(COIN_D0);
  localparam logic [W-1:0] D1 = W'(COIN_D1);
  localparam logic [W-1:0] D2 = W'(COIN_D2);
  localparam logic [W-1:0] D3 = W'(COIN_D3);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [W-1:0]     price_q, price_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [W-1:0]     change_q, change_d;
  logic [W-1:0]     rem_q, rem_d;
  logic             fail_q, fail_d;
  logic             gap_q, gap_d;
  logic [DCW-1:0]   disp_cnt_q, disp_cnt_d;

  logic             sel_valid;
  logic             sel_empty;
  logic             refund;
  logic [1:0]       coin_idx;
  logic [W-1:0]     coin_amt;

  assign sel_valid = 32'(sel_q) < N_ITEMS;
  assign refund    = !sel_valid || (sum_q < price_q) || sel_empty;

  // Largest denomination not exceeding the remainder; D3 covers any nonzero remainder.
  always_comb begin
    coin_idx = 2'd3;
    coin_amt = D3;
    if (rem_q >= D0) begin
      coin_idx = 2'd0;
      coin_amt = D0;
    end else if (rem_q >= D1) begin
      coin_idx = 2'd1;
      coin_amt = D1;
    end else if (rem_q >= D2) begin
      coin_idx = 2'd2;
      coin_amt = D2;
    end
  end

  // Moore outputs decoded from registered state; gap_q forces the idle cycle between coins.
  always_comb begin
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    ok         = (state_q == StDone) && !fail_q;
    change     = change_q;
    item_out   = (state_q == StDispense) ? (N_ITEMS'(1) << sel_q) : '0;
    coin_valid = (state_q == StChange) && (rem_q != '0) && !gap_q;
    coin_sel   = coin_valid ? coin_idx : 2'd0;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    price_d    = price_q;
    sum_d      = sum_q;
    change_d   = change_q;
    rem_d      = rem_q;
    fail_d     = fail_q;
    gap_d      = 1'b0;
    disp_cnt_d = disp_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (end_trans) begin
          sel_d   = item_select;
          price_d = price;
          sum_d   = sum_money;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (refund) begin
          change_d = sum_q;
          rem_d    = sum_q;
          fail_d   = 1'b1;
          state_d  = StChange;
        end else begin
          change_d   = sum_q - price_q;
          rem_d      = sum_q - price_q;
          fail_d     = 1'b0;
          disp_cnt_d = '0;
          state_d    = StDispense;
        end
      end
      StDispense: begin
        if (disp_cnt_q == DISP_LAST) begin
          state_d = StChange;
        end else begin
          disp_cnt_d = disp_cnt_q + 1'b1;
        end
      end
      StChange: begin
        if (rem_q == '0) begin
          state_d = StDone;
        end else if (coin_valid && coin_ready) begin
          rem_d = rem_q - coin_amt;
          gap_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      price_q    <= '0;
      sum_q      <= '0;
      change_q   <= '0;
      rem_q      <= '0;
      fail_q     <= 1'b0;
      gap_q      <= 1'b0;
      disp_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      price_q    <= price_d;
      sum_q      <= sum_d;
      change_q   <= change_d;
      rem_q      <= rem_d;
      fail_q     <= fail_d;
      gap_q      <= gap_d;
      disp_cnt_q <= disp_cnt_d;
    end
  end

`ifdef STOCK_TRACK_EN
  logic [STOCK_W-1:0] stock_q [N_ITEMS];
  logic [STOCK_W-1:0] stock_d [N_ITEMS];
  logic [N_ITEMS-1:0] sold_out_q;

  assign sold_out = sold_out_q;

  // Selected item's stock is empty; out-of-range selections are handled by sel_valid.
  always_comb begin
    sel_empty = 1'b0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (32'(sel_q) == i) begin
        sel_empty = (stock_q[i] == '0);
      end
    end
  end

  // Reload on restock while idle; decrement (saturating) on the CHECK -> DISPENSE transition.
  always_comb begin
    for (int i = 0; i < N_ITEMS; i++) begin
      stock_d[i] = stock_q[i];
      if (state_q == StIdle && restock) begin
        stock_d[i] = STOCK_W'(STOCK_INIT);
      end else if (state_q == StCheck && !refund && 32'(sel_q) == i && stock_q[i] != '0) begin
        stock_d[i] = stock_q[i] - 1'b1;
      end
    end
  end

  // Stock counters and registered sold_out flags.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_ITEMS; i++) begin
      if (!rst_n) begin
        stock_q[i]    <= STOCK_W'(STOCK_INIT);
        sold_out_q[i] <= (STOCK_INIT == 0);
      end else begin
        stock_q[i]    <= stock_d[i];
        sold_out_q[i] <= (stock_d[i] == '0);
      end
    end
  end
`else
  assign sel_empty = 1'b0;
`endif

endmodule

// File: tb/tb_vend_output_seq.sv
// Directed testbench for vend_output_seq. A second instance with N_ITEMS=3 exercises the
// invalid-selection refund. STOCK_TRACK_EN adds the stock scenario.
module tb_vend_output_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       end_trans = 1'b0;
  logic [1:0] item_select = '0;
  logic [7:0] price = '0;
  logic [7:0] sum_money = '0;
  logic       busy;
  logic [3:0] item_out;
  logic [7:0] change;
  logic       coin_valid;
  logic [1:0] coin_sel;
  logic       coin_ready = 1'b1;
  logic       done;
  logic       ok;

  logic       end_trans3 = 1'b0;
  logic [1:0] item_select3 = '0;
  logic [7:0] price3 = '0;
  logic [7:0] sum3 = '0;
  logic       busy3;
  logic [2:0] item_out3;
  logic [7:0] change3;
  logic       coin_valid3;
  logic [1:0] coin_sel3;
  logic       coin_ready3 = 1'b1;
  logic       done3;
  logic       ok3;

`ifdef STOCK_TRACK_EN
  logic       restock = 1'b0;
  logic [3:0] sold_out;
  logic       restock3 = 1'b0;
  logic [2:0] sold_out3;
`endif

  int         n_checks = 0;
  int         n_fail = 0;

  // Transaction recording.
  int         cyc;
  int         disp_n;
  int         first_item;
  int         n_coins;
  logic [3:0] item_val;
  logic [1:0] coins [8];
  logic       got_done;
  logic       ok_v;
  logic [7:0] change_v;

  always #5 clk = ~clk;

`ifdef STOCK_TRACK_EN
  vend_output_seq #(.STOCK_INIT(1)) dut (
`else
  vend_output_seq dut (
`endif
    .clk(clk), .rst_n(rst_n), .end_trans(end_trans), .item_select(item_select),
    .price(price), .sum_money(sum_money), .busy(busy), .item_out(item_out),
    .change(change), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .coin_ready(coin_ready), .done(done), .ok(ok)
`ifdef STOCK_TRACK_EN
    , .restock(restock), .sold_out(sold_out)
`endif
  );

  vend_output_seq #(.N_ITEMS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .end_trans(end_trans3), .item_select(item_select3),
    .price(price3), .sum_money(sum3), .busy(busy3), .item_out(item_out3),
    .change(change3), .coin_valid(coin_valid3), .coin_sel(coin_sel3),
    .coin_ready(coin_ready3), .done(done3), .ok(ok3)
`ifdef STOCK_TRACK_EN
    , .restock(restock3), .sold_out(sold_out3)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_txn(input logic [1:0] s, input logic [7:0] p, input logic [7:0] m);
    item_select = s;
    price       = p;
    sum_money   = m;
    end_trans   = 1'b1;
    tick();
    end_trans   = 1'b0;
    cyc         = 1;
    disp_n      = 0;
    first_item  = -1;
    n_coins     = 0;
    item_val    = '0;
  endtask

  // Record dispense/coin activity until done (bounded); one extra tick past done.
  task automatic collect(input int budget);
    got_done = 1'b0;
    ok_v     = 1'b0;
    change_v = '0;
    for (int c = 0; c < budget; c++) begin
      if (item_out != '0) begin
        if (disp_n == 0) first_item = cyc;
        disp_n++;
        item_val = item_out;
      end
      if (coin_valid) begin
        if (n_coins < 8) coins[n_coins] = coin_sel;
        n_coins++;
      end
      if (done) begin
        got_done = 1'b1;
        ok_v     = ok;
        change_v = change;
        break;
      end
      tick();
      cyc++;
    end
    if (got_done) tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({busy, item_out, change, coin_valid, coin_sel, done, ok} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {busy, item_out, change, coin_valid, coin_sel, done, ok});
    end
`ifdef STOCK_TRACK_EN
    n_checks++;
    if (sold_out !== 4'b0000) begin
      n_fail++; $display("FAIL reset_sold_out: got %b expected 0000", sold_out);
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

`ifdef STOCK_TRACK_EN
  task automatic test_stock;
    start_txn(2'd0, 8'd10, 8'd10);
    collect(40);
    n_checks++;
    if (got_done !== 1'b1 || ok_v !== 1'b1) begin
      n_fail++; $display("FAIL stock_first_ok: got done=%b ok=%b expected 1 1", got_done, ok_v);
    end
    n_checks++;
    if (sold_out !== 4'b0001) begin
      n_fail++; $display("FAIL stock_sold_out: got %b expected 0001", sold_out);
    end
    start_txn(2'd0, 8'd10, 8'd10);
    collect(40);
    n_checks++;
    if (got_done !== 1'b1 || ok_v !== 1'b0 || disp_n !== 0) begin
      n_fail++;
      $display("FAIL stock_refund: got done=%b ok=%b disp=%0d expected 1 0 0",
               got_done, ok_v, disp_n);
    end
    n_checks++;
    if (change_v !== 8'd10 || n_coins !== 1 || coins[0] !== 2'd1) begin
      n_fail++;
      $display("FAIL stock_refund_coins: got change=%0d coins=%0d first=%0d expected 10 1 1",
               change_v, n_coins, coins[0]);
    end
    restock = 1'b1;
    tick();
    restock = 1'b0;
    n_checks++;
    if (sold_out !== 4'b0000) begin
      n_fail++; $display("FAIL stock_restock: got %b expected 0000", sold_out);
    end
  endtask
`endif

  task automatic test_purchase;
    logic [1:0] exp_c [4];
    exp_c = '{2'd0, 2'd0, 2'd0, 2'd2};
    start_txn(2'd2, 8'd35, 8'd100);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL purchase_busy: got %b expected 1", busy);
    end
    collect(60);
    n_checks++;
    if (got_done !== 1'b1 || ok_v !== 1'b1) begin
      n_fail++; $display("FAIL purchase_done_ok: got done=%b ok=%b expected 1 1", got_done, ok_v);
    end
    n_checks++;
    if (first_item !== 2 || disp_n !== 2 || item_val !== 4'b0100) begin
      n_fail++;
      $display("FAIL purchase_dispense: got first=%0d cycles=%0d item=%b expected 2 2 0100",
               first_item, disp_n, item_val);
    end
    n_checks++;
    if (change_v !== 8'd65) begin
      n_fail++; $display("FAIL purchase_change: got %0d expected 65", change_v);
    end
    n_checks++;
    if (n_coins !== 4) begin
      n_fail++; $display("FAIL purchase_coin_count: got %0d expected 4", n_coins);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (coins[i] !== exp_c[i]) begin
        n_fail++; $display("FAIL purchase_coin%0d: got %0d expected %0d", i, coins[i], exp_c[i]);
      end
    end
    n_checks++;
    if (busy !== 1'b0 || change !== 8'd65) begin
      n_fail++;
      $display("FAIL purchase_after_done: got busy=%b change=%0d expected 0 65", busy, change);
    end
  endtask

  task automatic test_underpay;
    start_txn(2'd1, 8'd45, 8'd30);
    collect(60);
    n_checks++;
    if (got_done !== 1'b1 || ok_v !== 1'b0) begin
      n_fail++; $display("FAIL underpay_done_ok: got done=%b ok=%b expected 1 0", got_done, ok_v);
    end
    n_checks++;
    if (disp_n !== 0) begin
      n_fail++; $display("FAIL underpay_no_item: got %0d dispense cycles expected 0", disp_n);
    end
    n_checks++;
    if (change_v !== 8'd30 || n_coins !== 2 || coins[0] !== 2'd0 || coins[1] !== 2'd1) begin
      n_fail++;
      $display("FAIL underpay_coins: got change=%0d n=%0d c0=%0d c1=%0d expected 30 2 0 1",
               change_v, n_coins, coins[0], coins[1]);
    end
  endtask

  task automatic test_exact;
    start_txn(2'd0, 8'd50, 8'd50);
    collect(60);
    n_checks++;
    if (got_done !== 1'b1 || ok_v !== 1'b1) begin
      n_fail++; $display("FAIL exact_done_ok: got done=%b ok=%b expected 1 1", got_done, ok_v);
    end
    n_checks++;
    if (disp_n !== 2 || item_val !== 4'b0001) begin
      n_fail++;
      $display("FAIL exact_dispense: got cycles=%0d item=%b expected 2 0001", disp_n, item_val);
    end
    n_checks++;
    if (change_v !== 8'd0 || n_coins !== 0) begin
      n_fail++;
      $display("FAIL exact_no_coins: got change=%0d coins=%0d expected 0 0", change_v, n_coins);
    end
  endtask

  task automatic test_invalid_sel;
    int         d3 = 0;
    int         nc = 0;
    logic [1:0] c3 [4];
    logic       seen = 1'b0;
    logic       okr = 1'b1;
    logic [7:0] chg = '0;
    item_select3 = 2'd3;
    price3       = 8'd10;
    sum3         = 8'd25;
    end_trans3   = 1'b1;
    tick();
    end_trans3   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (item_out3 != '0) d3++;
      if (coin_valid3) begin
        if (nc < 4) c3[nc] = coin_sel3;
        nc++;
      end
      if (done3) begin
        seen = 1'b1;
        okr  = ok3;
        chg  = change3;
        break;
      end
      tick();
    end
    tick();
    n_checks++;
    if (seen !== 1'b1 || okr !== 1'b0 || d3 !== 0) begin
      n_fail++;
      $display("FAIL invalid_sel_refund: got done=%b ok=%b disp=%0d expected 1 0 0", seen, okr, d3);
    end
    n_checks++;
    if (chg !== 8'd25 || nc !== 2 || c3[0] !== 2'd0 || c3[1] !== 2'd2) begin
      n_fail++;
      $display("FAIL invalid_sel_coins: got change=%0d n=%0d c0=%0d c1=%0d expected 25 2 0 2",
               chg, nc, c3[0], c3[1]);
    end
  endtask

  task automatic test_backpressure;
    int wait_c = 0;
    coin_ready = 1'b0;
    start_txn(2'd1, 8'd10, 8'd40);
    while (!coin_valid && wait_c < 20) begin
      tick();
      wait_c++;
    end
    n_checks++;
    if (coin_valid !== 1'b1) begin
      n_fail++; $display("FAIL backpressure_offer: got coin_valid=%b expected 1", coin_valid);
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (coin_valid !== 1'b1 || coin_sel !== 2'd0) begin
        n_fail++;
        $display("FAIL backpressure_hold%0d: got valid=%b sel=%0d expected 1 0",
                 k, coin_valid, coin_sel);
      end
      if (k == 2) begin
        item_select = 2'd2;
        price       = 8'd0;
        sum_money   = 8'd99;
        end_trans   = 1'b1;
      end
      tick();
      end_trans = 1'b0;
    end
    n_coins    = 0;
    coin_ready = 1'b1;
    collect(40);
    n_checks++;
    if (got_done !== 1'b1 || ok_v !== 1'b1 || change_v !== 8'd30) begin
      n_fail++;
      $display("FAIL backpressure_done: got done=%b ok=%b change=%0d expected 1 1 30",
               got_done, ok_v, change_v);
    end
    n_checks++;
    if (n_coins !== 2 || coins[0] !== 2'd0 || coins[1] !== 2'd1) begin
      n_fail++;
      $display("FAIL backpressure_coins: got n=%0d c0=%0d c1=%0d expected 2 0 1",
               n_coins, coins[0], coins[1]);
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++; $display("FAIL ignored_end_trans%0d: got busy=%b expected 0", k, busy);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    int wait_c = 0;
    coin_ready = 1'b0;
    start_txn(2'd1, 8'd200, 8'd100);
    while (!coin_valid && wait_c < 20) begin
      tick();
      wait_c++;
    end
    n_checks++;
    if (coin_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_offer: got coin_valid=%b expected 1", coin_valid);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if ({busy, item_out, change, coin_valid, coin_sel, done, ok} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %b expected all zero",
               {busy, item_out, change, coin_valid, coin_sel, done, ok});
    end
    coin_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (coin_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_quiet%0d: got valid=%b busy=%b expected 0 0", k, coin_valid, busy);
      end
    end
    start_txn(2'd3, 8'd7, 8'd8);
    collect(40);
    n_checks++;
    if (got_done !== 1'b1 || ok_v !== 1'b1 || first_item !== 2 || item_val !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_mid_new_txn: got done=%b ok=%b first=%0d item=%b expected 1 1 2 1000",
               got_done, ok_v, first_item, item_val);
    end
    n_checks++;
    if (change_v !== 8'd1 || n_coins !== 1 || coins[0] !== 2'd3) begin
      n_fail++;
      $display("FAIL reset_mid_new_coins: got change=%0d n=%0d c0=%0d expected 1 1 3",
               change_v, n_coins, coins[0]);
    end
  endtask

  initial begin
    test_reset();
`ifdef STOCK_TRACK_EN
    test_stock();
`endif
    test_purchase();
    test_underpay();
    test_exact();
    test_invalid_sel();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
